fp_peak_search: RTL and testbench

Streaming peak detector for positive IEEE-754 single-precision values, e.g. FFT output magnitudes. It accepts a frame of N samples over a valid/ready input and tracks the largest value and the index where it first occurs, applying the magnitude ordering the datapath uses everywhere (bit 31 ignored). When the frame ends it presents the peak value and index on a valid/ready result port. It holds that result until the result is consumed.

---
 rtl/fp_peak_search.sv | 98 +++++++++
 tb/tb_fp_peak_search.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_peak_search.sv
// Streaming peak detector for float32 magnitudes (sign bit ignored). Reports the first
// index of the largest sample in each N-sample frame over a valid/ready result port.
module fp_peak_search #(
  parameter int unsigned N     = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [IDX_W-1:0] LastCnt = IDX_W'(N - 1);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        max_q, max_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_max_q, out_max_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;

  logic               take_new;
  logic [31:0]        new_max;
  logic [IDX_W-1:0]   new_idx;

  // Bits [30:0] as one unsigned word order exponent first, then mantissa.
  assign take_new = (cnt_q == '0) || (in_data[30:0] > max_q[30:0]);
  assign new_max  = take_new ? in_data : max_q;
  assign new_idx  = take_new ? cnt_q : idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    unique case (state_q)
      StAcc: begin
        if (in_valid) begin
          max_d = new_max;
          idx_d = new_idx;
          if (cnt_q == LastCnt) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_max_d   = new_max;
            out_idx_d   = new_idx;
            state_d     = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fp_peak_search.sv
// Self-checking bench for fp_peak_search with N=4: directed frames plus randomized frames
// compared against a frame-level peak model.
module tb_fp_peak_search;

  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_max;
  logic [IDX_W-1:0] out_idx;

  int total = 0;
  int bad   = 0;

  logic [31:0] cur [N];
  logic [31:0] exp_max;
  int          exp_idx;

  fp_peak_search #(.N(N), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_idx  (out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, expv, $time);
    end
  endtask

  // Peak = largest magnitude, ties resolved to the lowest index.
  task automatic ref_peak();
    exp_max = cur[0];
    exp_idx = 0;
    for (int i = 1; i < N; i++) begin
      if ({1'b0, cur[i][30:0]} > {1'b0, exp_max[30:0]}) begin
        exp_max = cur[i];
        exp_idx = i;
      end
    end
  endtask

  task automatic accept(input logic [31:0] d);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      ok       = in_ready;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic run_frame(input bit gaps, input bit ordy);
    ref_peak();
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(cur[i]);
    end
    chk("done_valid", {31'd0, out_valid}, 32'd1);
    chk("done_max", out_max, exp_max);
    chk("done_idx", {30'd0, out_idx}, exp_idx);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    if (ordy) begin
      @(posedge clk);
      #1;
      chk("hs_valid", {31'd0, out_valid}, 32'd0);
      chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_max", out_max, 32'd0);
    chk("rst_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set4(input logic [31:0] a, b, c, d);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
  endtask

  initial begin
    logic [31:0] pool [6];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    pool[0] = 32'h0000_0000; pool[1] = 32'h3F80_0000; pool[2] = 32'h4000_0000;
    pool[3] = 32'h3FFF_FFFF; pool[4] = 32'h7F80_0000; pool[5] = 32'h7FC0_0001;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", {31'd0, out_valid}, 32'd0);
    chk("init_max", out_max, 32'd0);
    chk("init_idx", {30'd0, out_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic frame, out_ready held high.
    set4(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F00_0000);
    run_frame(1'b0, 1'b1);
    chk("basic_idx_const", {30'd0, out_idx}, 32'd1);

    // Tie with a sign-flipped equal value keeps index 0.
    set4(32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 32'h3F80_0000);
    run_frame(1'b0, 1'b1);

    // Exponent beats mantissa; peak at the last slot.
    set4(32'h3FFF_FFFF, 32'h4000_0000, 32'h0000_0000, 32'h3FFF_FFFF);
    run_frame(1'b0, 1'b1);
    set4(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000);
    run_frame(1'b0, 1'b1);

    // Backpressure: result held, offered inputs ignored.
    set4(32'h4100_0000, 32'h3F80_0000, 32'hC120_0000, 32'h4120_0000);
    run_frame(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom | 32'h7F00_0000;
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_max", out_max, exp_max);
      chk("bp_idx", {30'd0, out_idx}, exp_idx);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    set4(32'h3F00_0000, 32'h3E00_0000, 32'h3F00_0001, 32'h3F00_0000);
    run_frame(1'b0, 1'b1);

    // Gaps give the same result.
    set4(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F00_0000);
    run_frame(1'b1, 1'b1);

    // Reset mid-frame discards the partial frame.
    accept(32'h7F7F_FFFF);
    accept(32'h7F00_0000);
    do_reset();
    set4(32'h3F80_0000, 32'h3F00_0000, 32'h4000_0000, 32'h3E00_0000);
    run_frame(1'b0, 1'b1);

    // Reset while a result is pending.
    set4(32'h4000_0000, 32'h4100_0000, 32'h4200_0000, 32'h4300_0000);
    run_frame(1'b0, 1'b0);
    do_reset();
    out_ready = 1'b1;

    // Randomized frames: pool values with random signs force ties and Inf/NaN exponents.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) cur[i] = pool[$urandom_range(0, 5)] ^ {$urandom_range(0, 1) == 1, 31'd0};
        else cur[i] = $urandom;
      end
      run_frame($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      if (!out_ready) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        chk("rnd_hold_max", out_max, exp_max);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rnd_release_valid", {31'd0, out_valid}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
